ibex_rf_multi_ctx: RTL and testbench

- Multi-context integer register file bank on the core's external RF port. Consumes read/write addresses, write data and context select from the core; returns read data.
- Holds NumRegFiles independent register sets (x1..x31, or x1..x15 for RV32E) and selects one per cycle.
- Contains a context-initialisation engine that clears a chosen context to WordZeroVal, one register per cycle, while the other contexts stay usable.

---
 rtl/ibex_rf_multi_ctx_pkg.sv | 16 +
 rtl/ibex_rf_ctx_init_fsm.sv | 89 ++++++++
 rtl/ibex_rf_multi_ctx.sv | 109 ++++++++++
 tb/tb_ibex_rf_multi_ctx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_multi_ctx_pkg.sv
// Shared types and helpers for the multi-context register file bank.
package ibex_rf_multi_ctx_pkg;

    // Context-clear engine states
    typedef enum logic [1:0] {
        InitIdle  = 2'd0,
        InitClear = 2'd1,
        InitDone  = 2'd2
    } rf_init_state_e;

    // Width of a context index; a single context still needs one select bit
    function automatic int RegFileCtxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibex_rf_ctx_init_fsm.sv
// Context-clear engine: walks x1..xLast of one latched context, one register
// per cycle, and reports busy while walking and a single done pulse after.
module ibex_rf_ctx_init_fsm
    import ibex_rf_multi_ctx_pkg::*;
#(
    parameter int unsigned NumRegFiles = 4,
    parameter bit          RV32E       = 1'b0,
    localparam int unsigned CtxW       = RegFileCtxW(NumRegFiles)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            init_req_i,
    input  logic [CtxW-1:0] init_ctx_i,
    output logic            clr_we_o,
    output logic [4:0]      clr_addr_o,
    output logic [CtxW-1:0] clr_ctx_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam logic [CtxW:0] NumCtx  = (CtxW+1)'(NumRegFiles);
    localparam logic [4:0]    LastReg = RV32E ? 5'd15 : 5'd31;

    rf_init_state_e  state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [CtxW-1:0] ctx_q, ctx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            InitIdle: begin
                if (init_req_i) begin
                    if ({1'b0, init_ctx_i} < NumCtx) begin
                        ctx_d   = init_ctx_i;
                        cnt_d   = 5'd1;
                        state_d = InitClear;
                        busy_d  = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            InitClear: begin
                if (cnt_q == LastReg) begin
                    state_d = InitDone;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    busy_d = 1'b1;
                end
            end
            InitDone: state_d = InitIdle;
            default:  state_d = InitIdle;
        endcase
    end

    // FSM state, counter, latched context and status flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= InitIdle;
            cnt_q   <= 5'd0;
            ctx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctx_q   <= ctx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_we_o   = (state_q == InitClear);
    assign clr_addr_o = cnt_q;
    assign clr_ctx_o  = ctx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/ibex_rf_multi_ctx.sv
// Multi-context integer register file: NumRegFiles register sets selected by
// ctx_sel_i, with a background engine that clears one context at a time.
module ibex_rf_multi_ctx
    import ibex_rf_multi_ctx_pkg::*;
#(
    parameter int unsigned          NumRegFiles = 4,
    parameter int unsigned          DataWidth   = 32,
    parameter bit                   RV32E       = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    localparam int unsigned         CtxW        = RegFileCtxW(NumRegFiles)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CtxW-1:0]      ctx_sel_i,
    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 we_i,
    input  logic                 init_req_i,
    input  logic [CtxW-1:0]      init_ctx_i,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    output logic                 err_o
);

    localparam int unsigned   NumRegs = RV32E ? 16 : 32;
    localparam int unsigned   AddrW   = RV32E ? 4 : 5;
    localparam logic [CtxW:0] NumCtx  = (CtxW+1)'(NumRegFiles);

    logic [NumRegFiles-1:0][NumRegs-1:0][DataWidth-1:0] mem_q, mem_d;

    logic            clr_we;
    logic [4:0]      clr_addr;
    logic [CtxW-1:0] clr_ctx;
    logic            init_err;

    logic            ctx_ok, ctx_blocked;
    logic [CtxW-1:0] ctx_idx;
    logic            wr_hit, wr_err, wr_en;
    logic            err_q, err_d;

    ibex_rf_ctx_init_fsm #(
        .NumRegFiles (NumRegFiles),
        .RV32E       (RV32E)
    ) u_init_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .init_req_i (init_req_i),
        .init_ctx_i (init_ctx_i),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_ctx_o  (clr_ctx),
        .busy_o     (init_busy_o),
        .done_o     (init_done_o),
        .err_o      (init_err)
    );

    // Context legality; the clamped index keeps illegal contexts from
    // addressing past the end of the storage array
    assign ctx_ok      = ({1'b0, ctx_sel_i} < NumCtx);
    assign ctx_idx     = ctx_ok ? ctx_sel_i : '0;
    assign ctx_blocked = init_busy_o && (ctx_sel_i == clr_ctx);

    // Zero-latency reads; x0, RV32E upper half, illegal or clearing context read as zero
    always_comb begin
        rdata_a_o = WordZeroVal;
        rdata_b_o = WordZeroVal;
        if (ctx_ok && !ctx_blocked) begin
            if ((raddr_a_i != 5'd0) && !(RV32E && raddr_a_i[4]))
                rdata_a_o = mem_q[ctx_idx][raddr_a_i[AddrW-1:0]];
            if ((raddr_b_i != 5'd0) && !(RV32E && raddr_b_i[4]))
                rdata_b_o = mem_q[ctx_idx][raddr_b_i[AddrW-1:0]];
        end
    end

    // Core write qualification; x0 writes vanish without an error
    always_comb begin
        wr_hit = we_i && (waddr_i != 5'd0);
        wr_err = wr_hit && (!ctx_ok || (RV32E && waddr_i[4]) || ctx_blocked);
        wr_en  = wr_hit && !wr_err;
        err_d  = wr_err || init_err;
    end

    // Storage update: clear write and core write never target the same context
    always_comb begin
        mem_d = mem_q;
        if (clr_we)
            mem_d[clr_ctx][clr_addr[AddrW-1:0]] = WordZeroVal;
        if (wr_en)
            mem_d[ctx_idx][waddr_i[AddrW-1:0]] = wdata_i;
    end

    // Register storage and error pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= {(NumRegFiles*NumRegs){WordZeroVal}};
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_ibex_rf_multi_ctx.sv
// Bench for ibex_rf_multi_ctx: DUT 0 is the default 4-context RV32I bank,
// DUT 1 is a 3-context RV32E bank. A reference model of register contents
// feeds a queue of expected read/error values that is drained as outputs appear.
module tb_ibex_rf_multi_ctx;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctx  [2];
    logic [1:0]  ictx [2];
    logic [4:0]  ra   [2];
    logic [4:0]  rb   [2];
    logic [4:0]  wa   [2];
    logic [31:0] wd   [2];
    logic [31:0] rda  [2];
    logic [31:0] rdb  [2];
    logic        we   [2];
    logic        ireq [2];
    logic        busy [2];
    logic        done [2];
    logic        err  [2];

    logic [31:0] mdl [2][4][32];
    logic [31:0] sb  [$];
    logic        eq  [$];
    int          nvec = 0;
    int          nerr = 0;

    ibex_rf_multi_ctx #(.NumRegFiles(4), .DataWidth(32), .RV32E(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .ctx_sel_i(ctx[0]),
        .raddr_a_i(ra[0]), .rdata_a_o(rda[0]), .raddr_b_i(rb[0]), .rdata_b_o(rdb[0]),
        .waddr_i(wa[0]), .wdata_i(wd[0]), .we_i(we[0]),
        .init_req_i(ireq[0]), .init_ctx_i(ictx[0]),
        .init_busy_o(busy[0]), .init_done_o(done[0]), .err_o(err[0])
    );

    ibex_rf_multi_ctx #(.NumRegFiles(3), .DataWidth(32), .RV32E(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .ctx_sel_i(ctx[1]),
        .raddr_a_i(ra[1]), .rdata_a_o(rda[1]), .raddr_b_i(rb[1]), .rdata_b_o(rdb[1]),
        .waddr_i(wa[1]), .wdata_i(wd[1]), .we_i(we[1]),
        .init_req_i(ireq[1]), .init_ctx_i(ictx[1]),
        .init_busy_o(busy[1]), .init_done_o(done[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nrf(input int w);
        return (w == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] exp_rd(input int w, input int c, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (w == 1 && a[4]) return 32'h0;
        if (c >= nrf(w)) return 32'h0;
        return mdl[w][c][a];
    endfunction

    function automatic bit exp_werr(input int w, input int c, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return (c >= nrf(w)) || (w == 1 && a[4]);
    endfunction

    task automatic zero_model();
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < 4; c++)
                for (int a = 0; a < 32; a++) mdl[w][c][a] = 32'h0;
    endtask

    // Drive both read ports in the current cycle and check after settling
    task automatic rd_now(input int w, input int c, input logic [4:0] a, input bit blk, input string nm);
        logic [4:0]  b;
        logic [31:0] e;
        b = ~a;
        ctx[w] = 2'(c);
        ra[w]  = a;
        rb[w]  = b;
        sb.push_back(blk ? 32'h0 : exp_rd(w, c, a));
        sb.push_back(blk ? 32'h0 : exp_rd(w, c, b));
        #1;
        e = sb.pop_front();
        nvec++;
        if (rda[w] !== e) begin
            nerr++;
            $display("FAIL %s dut%0d portA ctx%0d x%0d: got %h want %h", nm, w, c, a, rda[w], e);
        end
        e = sb.pop_front();
        nvec++;
        if (rdb[w] !== e) begin
            nerr++;
            $display("FAIL %s dut%0d portB ctx%0d x%0d: got %h want %h", nm, w, c, b, rdb[w], e);
        end
    endtask

    task automatic rd_all(input int w, input string nm);
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 32; a++) begin
                @(negedge clk);
                rd_now(w, c, 5'(a), 1'b0, nm);
            end
    endtask

    // One-cycle core write; checks no-bypass before the edge and err_o after it
    task automatic wr(input int w, input int c, input logic [4:0] a, input logic [31:0] d, input string nm);
        bit ee, eg;
        @(negedge clk);
        wa[w] = a;
        wd[w] = d;
        we[w] = 1'b1;
        rd_now(w, c, a, 1'b0, {nm, "_prewrite"});
        ee = exp_werr(w, c, a);
        eq.push_back(ee);
        @(negedge clk);
        we[w] = 1'b0;
        eg = eq.pop_front();
        nvec++;
        if (err[w] !== eg) begin
            nerr++;
            $display("FAIL %s dut%0d err_o: got %b want %b", nm, w, err[w], eg);
        end
        if (!ee && a != 5'd0) mdl[w][c][a] = d;
    endtask

    task automatic chk_bit(input logic got, input logic want, input string nm, input int k);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %b want %b", nm, k, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            ctx[w] = '0; ictx[w] = '0; ra[w] = '0; rb[w] = '0;
            wa[w] = '0; wd[w] = '0; we[w] = 1'b0; ireq[w] = 1'b0;
        end
        zero_model();
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk_bit(busy[w], 1'b0, "reset_busy", 0);
            chk_bit(done[w], 1'b0, "reset_done", 0);
            chk_bit(err[w],  1'b0, "reset_err",  0);
        end
        rst_n = 1'b1;
        rd_all(0, "reset_read");
        rd_all(1, "reset_read");
    endtask

    task automatic test_basic_write();
        wr(0, 2, 5'd5, 32'hDEADBEEF, "wr_ctx2_x5");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rd_now(0, c, 5'd5, 1'b0, "read_x5");
        end
        wr(0, 0, 5'd0, 32'hFFFFFFFF, "wr_x0");
        @(negedge clk);
        rd_now(0, 0, 5'd0, 1'b0, "read_x0");
    endtask

    task automatic test_clear_with_traffic();
        for (int n = 1; n < 32; n++) begin
            wr(0, 1, 5'(n), 32'(n), "fill_ctx1");
            wr(0, 0, 5'(n), 32'(n + 100), "fill_ctx0");
        end
        @(negedge clk);
        ireq[0] = 1'b1;
        ictx[0] = 2'd1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            ireq[0] = 1'b0;
            we[0]   = 1'b0;
            chk_bit(busy[0], (k <= 31), "clr_busy", k);
            chk_bit(done[0], (k == 32), "clr_done", k);
            if (k == 4) chk_bit(err[0], 1'b1, "clr_blocked_wr_err", k);
            if (k == 6 || k == 9) chk_bit(err[0], 1'b0, "clr_other_err", k);
            case (k)
                2: rd_now(0, 1, 5'd20, 1'b1, "clr_blocked_read");
                3: begin
                    ctx[0] = 2'd1; wa[0] = 5'd4; wd[0] = 32'hAAAA5555; we[0] = 1'b1;
                end
                5: begin
                    ctx[0] = 2'd3; wa[0] = 5'd7; wd[0] = 32'h12345678; we[0] = 1'b1;
                    mdl[0][3][7] = 32'h12345678;
                end
                6:  rd_now(0, 3, 5'd7, 1'b0, "clr_ctx3_write_visible");
                8:  begin ireq[0] = 1'b1; ictx[0] = 2'd2; end
                13: rd_now(0, 0, 5'd9, 1'b0, "clr_ctx0_readable");
                default: ;
            endcase
        end
        for (int a = 0; a < 32; a++) mdl[0][1][a] = 32'h0;
        rd_all(0, "after_clear");
    endtask

    task automatic test_rv32e_ctx3();
        wr(1, 0, 5'd16, 32'h0BAD0BAD, "e_wr_x16");
        wr(1, 3, 5'd5, 32'h55555555, "n3_wr_ctx3");
        @(negedge clk);
        rd_now(1, 3, 5'd5, 1'b0, "n3_rd_ctx3");
        ireq[1] = 1'b1;
        ictx[1] = 2'd3;
        @(negedge clk);
        ireq[1] = 1'b0;
        chk_bit(err[1],  1'b1, "n3_init_ctx3_err",  1);
        chk_bit(busy[1], 1'b0, "n3_init_ctx3_busy", 1);
        for (int n = 1; n < 16; n++) wr(1, 0, 5'(n), 32'hC000_0000 | 32'(n), "e_fill_ctx0");
        wr(1, 2, 5'd9, 32'h0000_2222, "e_fill_ctx2");
        @(negedge clk);
        ireq[1] = 1'b1;
        ictx[1] = 2'd0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            ireq[1] = 1'b0;
            chk_bit(busy[1], (k <= 15), "e_clr_busy", k);
            chk_bit(done[1], (k == 16), "e_clr_done", k);
        end
        for (int a = 0; a < 32; a++) mdl[1][0][a] = 32'h0;
        rd_all(1, "e_after_clear");
    endtask

    task automatic test_reset_mid_clear();
        wr(0, 2, 5'd3, 32'h33333333, "rst_fill0");
        wr(1, 1, 5'd2, 32'h22222222, "rst_fill1");
        @(negedge clk);
        ireq[1] = 1'b1;
        ictx[1] = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            ireq[1] = 1'b0;
            chk_bit(busy[1], 1'b1, "rst_pre_busy", k);
        end
        rst_n = 1'b0;
        #1;
        chk_bit(busy[1], 1'b0, "rst_async_busy", 5);
        @(negedge clk);
        chk_bit(busy[1], 1'b0, "rst_busy", 6);
        chk_bit(done[1], 1'b0, "rst_done", 6);
        rst_n = 1'b1;
        zero_model();
        for (int k = 7; k <= 26; k++) begin
            @(negedge clk);
            chk_bit(busy[1], 1'b0, "rst_after_busy", k);
            chk_bit(done[1], 1'b0, "rst_after_done", k);
        end
        rd_all(0, "rst_read0");
        rd_all(1, "rst_read1");
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_clear_with_traffic();
        test_rv32e_ctx3();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
